// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared types and constants for the Tetris playfield renderer.
//   piece_t       : 3-bit cell code, EMPTY = 0, then the seven tetrominoes.
//   clr_state_t   : row-clear FSM state encoding (also exported for debug).
//   piece_color() : 12-bit RGB (4 bits per channel) for a piece code.
//   bevel_color() : per-channel +4, saturating at F (used for bevelled edges).
//   *_DEF         : default geometry (board at x=100, 24 px cells, 10x20).
// -----------------------------------------------------------------------------
package tetris_pkg;

  localparam int BOARD_X0_DEF = 100;
  localparam int CELL_PX_DEF  = 24;
  localparam int COLS_DEF     = 10;
  localparam int ROWS_DEF     = 20;

  typedef enum logic [2:0] {
    EMPTY = 3'd0,
    I     = 3'd1,
    O     = 3'd2,
    T     = 3'd3,
    S     = 3'd4,
    Z     = 3'd5,
    J     = 3'd6,
    L     = 3'd7
  } piece_t;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_SHIFT = 2'd1,
    CLR_ZERO  = 2'd2
  } clr_state_t;

  function automatic logic [11:0] piece_color(input piece_t p);
    logic [11:0] rgb;
    case (p)
      I:       rgb = 12'h0FF;
      O:       rgb = 12'hFF0;
      T:       rgb = 12'hA0F;
      S:       rgb = 12'h0F0;
      Z:       rgb = 12'hF00;
      J:       rgb = 12'h00F;
      L:       rgb = 12'hF80;
      default: rgb = 12'h000;
    endcase
    return rgb;
  endfunction

  function automatic logic [11:0] bevel_color(input logic [11:0] c);
    logic [11:0] r;
    logic [3:0]  nib;
    r = 12'h000;
    for (int k = 0; k < 3; k++) begin
      nib = c[k*4 +: 4];
      r[k*4 +: 4] = (nib > 4'd11) ? 4'hF : (nib + 4'd4);
    end
    return r;
  endfunction

endpackage

// File: rtl/tetris_cell_ram.sv
// -----------------------------------------------------------------------------
// tetris_cell_ram
// Playfield storage (ROWS x COLS cells of 3-bit piece codes) with a single
// write port, a row-clear/collapse engine and a combinational read port.
//   clk, rst_n          : clock, asynchronous active-low reset (board -> EMPTY)
//   wr_en/wr_row/wr_col/wr_code : one-cell write, out-of-range ignored
//   clr_req/clr_row     : request removal of clr_row, rows above drop by one
//   rd_row/rd_col       : combinational read address, rd_code result
//                         (out-of-range address reads EMPTY)
//   busy                : row clear in progress
//   clr_done            : one-cycle pulse in the first idle cycle after a clear
//   state_o             : row-clear FSM state, for observation
//
// Request semantics: clr_req and wr_en are single-cycle commands sampled only
// while busy is low. There is no back-pressure: a command presented while busy
// is high is dropped, never queued. busy rises the cycle after an accepted
// clr_req and stays high for exactly clr_row+1 cycles.
// -----------------------------------------------------------------------------
module tetris_cell_ram
  import tetris_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [4:0] wr_row,
  input  logic [3:0] wr_col,
  input  logic [2:0] wr_code,
  input  logic       clr_req,
  input  logic [4:0] clr_row,
  input  logic [4:0] rd_row,
  input  logic [3:0] rd_col,
  output logic [2:0] rd_code,
  output logic       busy,
  output logic       clr_done,
  output clr_state_t state_o
);

  localparam logic [4:0] ROWS_L = 5'(ROWS);
  localparam logic [3:0] COLS_L = 4'(COLS);

  logic [2:0] cells_q [ROWS][COLS];
  logic [2:0] cells_d [ROWS][COLS];
  clr_state_t state_q, state_d;
  logic [4:0] cur_q, cur_d;
  logic       clr_done_q, clr_done_d;

  always_comb begin
    cells_d    = cells_q;
    state_d    = state_q;
    cur_d      = cur_q;
    clr_done_d = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (wr_en && (wr_row < ROWS_L) && (wr_col < COLS_L)) begin
          cells_d[wr_row][wr_col] = wr_code;
        end
        if (clr_req && (clr_row < ROWS_L)) begin
          cur_d   = clr_row;
          // Clearing the top row needs no shifting, only the blanking step.
          state_d = (clr_row == 5'd0) ? CLR_ZERO : CLR_SHIFT;
        end
      end
      CLR_SHIFT: begin
        // Pull the row above down into cur; one row per cycle, bottom-up so
        // every source row is still intact when it is copied.
        for (int c = 0; c < COLS; c++) begin
          cells_d[cur_q][c] = cells_q[5'(cur_q - 5'd1)][c];
        end
        cur_d = cur_q - 5'd1;
        if (cur_q == 5'd1) begin
          state_d = CLR_ZERO;
        end
      end
      CLR_ZERO: begin
        for (int c = 0; c < COLS; c++) begin
          cells_d[0][c] = EMPTY;
        end
        state_d    = CLR_IDLE;
        clr_done_d = 1'b1;
      end
      default: begin
        state_d = CLR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          cells_q[r][c] <= EMPTY;
        end
      end
      state_q    <= CLR_IDLE;
      cur_q      <= 5'd0;
      clr_done_q <= 1'b0;
    end else begin
      cells_q    <= cells_d;
      state_q    <= state_d;
      cur_q      <= cur_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign rd_code  = ((rd_row < ROWS_L) && (rd_col < COLS_L)) ? cells_q[rd_row][rd_col] : 3'd0;
  assign busy     = (state_q != CLR_IDLE);
  assign clr_done = clr_done_q;
  assign state_o  = state_q;

endmodule

// File: rtl/board_cell_renderer.sv
// -----------------------------------------------------------------------------
// board_cell_renderer
// Holds the Tetris playfield and renders it per pixel with a 2-stage pipeline.
//   Clk, Reset_n            : pixel clock, asynchronous active-low reset
//   DrawX, DrawY            : current pixel coordinates
//   hsync, vsync, de        : video timing, delayed 2 cycles to *_d outputs
//   wr_en/wr_row/wr_col/wr_code : write one cell (game logic side)
//   clr_req/clr_row         : remove a full row and collapse the rows above
//   busy, clr_done          : row-clear status (see tetris_cell_ram)
//   cell_on, Red/Green/Blue : pixel is inside an occupied cell interior, colour
//   DrawX_d, DrawY_d        : coordinates aligned with cell_on/colour
//   clr_state               : row-clear FSM state, for observation
// Stage 1 turns the pixel into (row, col, x_off, y_off, in_board); stage 2
// looks the cell up and produces colour. The first pixel row/column of every
// cell is left dark so the grid stays visible.
// Build option: define PIECE_BEVEL_EN to lighten (+4 per channel, saturating)
// the first lit row/column of each occupied cell; otherwise flat colour.
// -----------------------------------------------------------------------------
module board_cell_renderer
  import tetris_pkg::*;
#(
  parameter int BOARD_X0 = BOARD_X0_DEF,
  parameter int CELL_PX  = CELL_PX_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int ROWS     = ROWS_DEF
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       de,
  input  logic       wr_en,
  input  logic [4:0] wr_row,
  input  logic [3:0] wr_col,
  input  logic [2:0] wr_code,
  input  logic       clr_req,
  input  logic [4:0] clr_row,
  output logic       busy,
  output logic       clr_done,
  output logic       cell_on,
  output logic [3:0] Red,
  output logic [3:0] Green,
  output logic [3:0] Blue,
  output logic [9:0] DrawX_d,
  output logic [9:0] DrawY_d,
  output logic       hsync_d,
  output logic       vsync_d,
  output logic       de_d,
  output logic [1:0] clr_state
);

  localparam logic [9:0] X0   = 10'(BOARD_X0);
  localparam logic [9:0] XEND = 10'(BOARD_X0 + COLS * CELL_PX);
  localparam logic [9:0] YEND = 10'(ROWS * CELL_PX);
  localparam logic [9:0] CPX  = 10'(CELL_PX);

  // Stage 1 registers
  logic [3:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic [4:0] x_off_q, x_off_d;
  logic [4:0] y_off_q, y_off_d;
  logic       in_board_q, in_board_d;
  logic [9:0] x1_q, y1_q;
  logic       hs1_q, vs1_q, de1_q;

  // Stage 2 registers
  logic        cell_on_q, cell_on_d;
  logic [11:0] rgb_q, rgb_d;
  logic [9:0]  x2_q, y2_q;
  logic        hs2_q, vs2_q, de2_q;

  logic [9:0]  dx;
  logic [2:0]  code;
  clr_state_t  ram_state;

  tetris_cell_ram #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_ram (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .wr_en    (wr_en),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_code  (wr_code),
    .clr_req  (clr_req),
    .clr_row  (clr_row),
    .rd_row   (row_q),
    .rd_col   (col_q),
    .rd_code  (code),
    .busy     (busy),
    .clr_done (clr_done),
    .state_o  (ram_state)
  );

  // Stage 1: pixel -> cell coordinates. Outside the board the row/col values
  // are meaningless; in_board masks them in stage 2.
  always_comb begin
    dx         = DrawX - X0;
    col_d      = 4'(dx / CPX);
    x_off_d    = 5'(dx % CPX);
    row_d      = 5'(DrawY / CPX);
    y_off_d    = 5'(DrawY % CPX);
    in_board_d = (DrawX >= X0) && (DrawX < XEND) && (DrawY < YEND);
  end

  // Stage 2: cell lookup -> colour. The lookup sees the board as it stood
  // before this edge, so a write landing on the same edge shows next frame.
  always_comb begin
    cell_on_d = in_board_q && (code != 3'd0) && (x_off_q != 5'd0) && (y_off_q != 5'd0);
    rgb_d     = 12'h000;
    if (cell_on_d) begin
      rgb_d = piece_color(piece_t'(code));
`ifdef PIECE_BEVEL_EN
      if ((x_off_q == 5'd1) || (y_off_q == 5'd1)) begin
        rgb_d = bevel_color(rgb_d);
      end
`endif
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      col_q      <= 4'd0;
      row_q      <= 5'd0;
      x_off_q    <= 5'd0;
      y_off_q    <= 5'd0;
      in_board_q <= 1'b0;
      x1_q       <= 10'd0;
      y1_q       <= 10'd0;
      hs1_q      <= 1'b0;
      vs1_q      <= 1'b0;
      de1_q      <= 1'b0;
      cell_on_q  <= 1'b0;
      rgb_q      <= 12'h000;
      x2_q       <= 10'd0;
      y2_q       <= 10'd0;
      hs2_q      <= 1'b0;
      vs2_q      <= 1'b0;
      de2_q      <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      x_off_q    <= x_off_d;
      y_off_q    <= y_off_d;
      in_board_q <= in_board_d;
      x1_q       <= DrawX;
      y1_q       <= DrawY;
      hs1_q      <= hsync;
      vs1_q      <= vsync;
      de1_q      <= de;
      cell_on_q  <= cell_on_d;
      rgb_q      <= rgb_d;
      x2_q       <= x1_q;
      y2_q       <= y1_q;
      hs2_q      <= hs1_q;
      vs2_q      <= vs1_q;
      de2_q      <= de1_q;
    end
  end

  assign cell_on   = cell_on_q;
  assign Red       = rgb_q[11:8];
  assign Green     = rgb_q[7:4];
  assign Blue      = rgb_q[3:0];
  assign DrawX_d   = x2_q;
  assign DrawY_d   = y2_q;
  assign hsync_d   = hs2_q;
  assign vsync_d   = vs2_q;
  assign de_d      = de2_q;
  assign clr_state = ram_state;

endmodule

// File: tb/tb_board_cell_renderer.sv
// -----------------------------------------------------------------------------
// tb_board_cell_renderer
// Self-checking bench for board_cell_renderer. Rendered pixels are predicted
// from a bench-side board model when driven and compared two cycles later.
// -----------------------------------------------------------------------------
module tb_board_cell_renderer;

  // ---------------- clock / reset ----------------
  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  logic [9:0] DrawX = '0, DrawY = '0;
  logic       hsync = 1'b0, vsync = 1'b0, de = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_row = '0;
  logic [3:0] wr_col = '0;
  logic [2:0] wr_code = '0;
  logic       clr_req = 1'b0;
  logic [4:0] clr_row = '0;
  logic       busy, clr_done, cell_on;
  logic [3:0] Red, Green, Blue;
  logic [9:0] DrawX_d, DrawY_d;
  logic       hsync_d, vsync_d, de_d;
  logic [1:0] clr_state;

  board_cell_renderer dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .hsync(hsync), .vsync(vsync), .de(de),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_code(wr_code),
    .clr_req(clr_req), .clr_row(clr_row),
    .busy(busy), .clr_done(clr_done), .cell_on(cell_on),
    .Red(Red), .Green(Green), .Blue(Blue),
    .DrawX_d(DrawX_d), .DrawY_d(DrawY_d),
    .hsync_d(hsync_d), .vsync_d(vsync_d), .de_d(de_d),
    .clr_state(clr_state)
  );

  // ---------------- scoreboard state ----------------
  localparam int W = 36;  // {cell_on, rgb[11:0], x[9:0], y[9:0], hs, vs, de}
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  logic [2:0] board [20][10];
  logic       chk_now = 1'b0;
  logic [1:0] chk_sr  = 2'b00;
  logic       cnt_en  = 1'b0;
  int         busy_cnt = 0;
  int         done_cnt = 0;
  int         overlap  = 0;

  typedef struct {
    int          x;
    int          y;
    logic        on;
    logic [11:0] rgb;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] tb_color(input logic [2:0] code);
    case (code)
      3'd1: return 12'h0FF;
      3'd2: return 12'hFF0;
      3'd3: return 12'hA0F;
      3'd4: return 12'h0F0;
      3'd5: return 12'hF00;
      3'd6: return 12'h00F;
      3'd7: return 12'hF80;
      default: return 12'h000;
    endcase
  endfunction

`ifdef PIECE_BEVEL_EN
  function automatic logic [11:0] tb_bevel(input logic [11:0] c);
    logic [11:0] r;
    for (int k = 0; k < 3; k++) begin
      r[k*4 +: 4] = (c[k*4 +: 4] >= 4'hC) ? 4'hF : c[k*4 +: 4] + 4'h4;
    end
    return r;
  endfunction
`endif

  function automatic logic [12:0] model_px(input int x, input int y);
    int dx, c, r, xo, yo;
    logic [2:0]  code;
    logic        on;
    logic [11:0] rgb;
    code = 3'd0; xo = 0; yo = 0; rgb = 12'h000;
    if (x >= 100 && x < 340 && y < 480) begin
      dx = x - 100; c = dx / 24; xo = dx % 24;
      r = y / 24;   yo = y % 24;
      code = board[r][c];
    end
    on = (code != 3'd0) && (xo != 0) && (yo != 0);
    if (on) rgb = tb_color(code);
`ifdef PIECE_BEVEL_EN
    if (on && (xo == 1 || yo == 1)) rgb = tb_bevel(rgb);
`endif
    return {on, rgb};
  endfunction

  // ---------------- pipeline tag + monitor ----------------
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) chk_sr <= 2'b00;
    else          chk_sr <= {chk_sr[0], chk_now};
  end

  always @(negedge Clk) begin
    logic [W-1:0] e;
    if (chk_sr[1]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL render_pop: got an output with no expectation queued");
      end else begin
        e = exp_q.pop_front();
        check("render", {cell_on, Red, Green, Blue, DrawX_d, DrawY_d, hsync_d, vsync_d, de_d}, e);
      end
    end
    if (cnt_en) begin
      busy_cnt += busy;
      done_cnt += clr_done;
      if (busy && clr_done) overlap++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
    chk_now = 1'b0;
    wr_en   = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic px_exp(input int x, input int y, input logic [12:0] m);
    step();
    DrawX = 10'(x);
    DrawY = 10'(y);
    hsync = 1'($urandom_range(0, 1));
    vsync = 1'($urandom_range(0, 1));
    de    = 1'($urandom_range(0, 1));
    chk_now = 1'b1;
    exp_q.push_back({m, DrawX, DrawY, hsync, vsync, de});
  endtask

  task automatic px(input int x, input int y);
    px_exp(x, y, model_px(x, y));
  endtask

  task automatic flush();
    repeat (4) step();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_board();
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++)
        px(100 + c * 24 + 12, r * 24 + 12);
    flush();
  endtask

  task automatic wr_cell(input int r, input int c, input int code);
    step();
    wr_en = 1'b1; wr_row = 5'(r); wr_col = 4'(c); wr_code = 3'(code);
    if (r < 20 && c < 10) board[r][c] = 3'(code);
  endtask

  task automatic model_clear(input int row);
    for (int r = row; r > 0; r--)
      for (int c = 0; c < 10; c++) board[r][c] = board[r-1][c];
    for (int c = 0; c < 10; c++) board[0][c] = 3'd0;
  endtask

  task automatic cnt_start();
    busy_cnt = 0; done_cnt = 0; overlap = 0; cnt_en = 1'b1;
  endtask

  task automatic cnt_stop(input string tag, input int exp_busy, input int exp_done);
    repeat (40) @(negedge Clk);
    cnt_en = 1'b0;
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'(exp_done));
    check({tag, "_done_while_busy"}, 64'(overlap), 64'd0);
  endtask

  task automatic do_clear(input string tag, input int row, input int exp_busy, input int exp_done);
    cnt_start();
    step();
    clr_req = 1'b1; clr_row = 5'(row);
    if (row < 20) model_clear(row);
    step();
    cnt_stop(tag, exp_busy, exp_done);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[8];

  initial begin
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) board[r][c] = 3'd0;

    // 1: reset state with busy inputs present
    DrawX = 10'd200; DrawY = 10'd100; hsync = 1'b1; vsync = 1'b1; de = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_cell_on", 64'(cell_on), 64'd0);
    check("rst_rgb", 64'({Red, Green, Blue}), 64'd0);
    check("rst_drawx_d", 64'(DrawX_d), 64'd0);
    check("rst_drawy_d", 64'(DrawY_d), 64'd0);
    check("rst_syncs", 64'({hsync_d, vsync_d, de_d}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_clr_done", 64'(clr_done), 64'd0);
    check("rst_clr_state", 64'(clr_state), 64'd0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    // 1: coarse frame sweep on the empty board
    for (int y = 0; y < 480; y += 12)
      for (int x = 0; x < 640; x += 16) px(x, y + (x % 7));
    px(200, 500);
    px(1023, 1023);
    flush();

    // 2/3: single T cell at (0,0), table-driven pixel checks
    wr_cell(0, 0, 3);
    wr_cell(20, 0, 1);   // row out of range: ignored
    wr_cell(0, 10, 1);   // col out of range: ignored
    step();
    vecs[0] = '{105,   5, 1'b1, 12'hA0F};
    vecs[1] = '{100,   5, 1'b0, 12'h000};
    vecs[2] = '{105,   0, 1'b0, 12'h000};
    vecs[3] = '{340,   5, 1'b0, 12'h000};
    vecs[4] = '{123,  23, 1'b1, 12'hA0F};
    vecs[5] = '{124,   5, 1'b0, 12'h000};
    vecs[6] = '{ 99,   5, 1'b0, 12'h000};
    vecs[7] = '{105,  24, 1'b0, 12'h000};
    for (int i = 0; i < 8; i++) px_exp(vecs[i].x, vecs[i].y, {vecs[i].on, vecs[i].rgb});
    flush();
    check_board();

    // 4: full bottom row of I, Z above it, O at top; clear row 19
    for (int c = 0; c < 10; c++) wr_cell(19, c, 1);
    wr_cell(18, 3, 5);
    wr_cell(0, 5, 2);
    check_board();
    do_clear("clr19", 19, 20, 1);
    px_exp(100 + 3 * 24 + 12, 19 * 24 + 12, {1'b1, 12'hF00});
    px_exp(100 + 5 * 24 + 12, 12,           {1'b0, 12'h000});
    px_exp(100 + 5 * 24 + 12, 24 + 12,      {1'b1, 12'hFF0});
    px_exp(100 + 0 * 24 + 12, 24 + 12,      {1'b1, 12'hA0F});
    flush();
    check_board();

    // Out-of-range clear while idle, and clearing the top row directly
    do_clear("clr25", 25, 0, 0);
    wr_cell(0, 9, 6);
    check_board();
    do_clear("clr0", 0, 1, 1);
    check_board();

    // 5: commands during busy are dropped
    wr_cell(4, 2, 4);
    cnt_start();
    step();
    clr_req = 1'b1; clr_row = 5'd5;
    model_clear(5);
    step();
    wr_en = 1'b1; wr_row = 5'd10; wr_col = 4'd7; wr_code = 3'd7;
    step();
    clr_req = 1'b1; clr_row = 5'd3;
    step();
    clr_req = 1'b1; clr_row = 5'd25;
    step();
    cnt_stop("busy_drop", 6, 1);
    check_board();

`ifdef PIECE_BEVEL_EN
    // 6: bevelled edge of an I cell
    wr_cell(2, 2, 1);
    step();
    px_exp(149, 53, {1'b1, 12'h4FF});
    px_exp(153, 53, {1'b1, 12'h0FF});
    flush();
`endif

    // Reset in the middle of a clear: no clr_done, board emptied
    wr_cell(12, 4, 2);
    step();
    clr_req = 1'b1; clr_row = 5'd19;
    repeat (5) step();
    cnt_start();
    Reset_n = 1'b0;
    #2;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_state", 64'(clr_state), 64'd0);
    step();
    Reset_n = 1'b1;
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) board[r][c] = 3'd0;
    cnt_stop("midrst", 0, 0);
    check_board();

    flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound on total simulated time.
  initial begin
    #900000;
    $display("FAIL timeout: got no end of test expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
